// File: rtl/nonrestoring_div_if.sv
// Start/done handshake and result bus of the sequential non-restoring divider.
// The master drives operands and the start strobe; the slave returns the result and op counters.
interface nonrestoring_div_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
);
    logic             inp;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             done;
    logic [CW-1:0]    adds;
    logic [CW-1:0]    subs;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             divzero;

    modport master (
        output inp, dvd, dvs,
        input  done, adds, subs, quot, rem, divzero
    );

    modport slave (
        input  inp, dvd, dvs,
        output done, adds, subs, quot, rem, divzero
    );
endinterface

// File: rtl/nonrestoring_div.sv
// Sequential signed divider, one quotient bit per clock (non-restoring), with add/sub op counters.
// Define DIV_SKIP_LZ_EN to pre-shift the leading zeros of |dvd| out and run only the remaining iterations.
module nonrestoring_div #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    nonrestoring_div_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_SIGN,
        S_ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH-1:0] dvs_abs_q, dvs_abs_d;
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dvs_q, neg_dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    adds_q, adds_d;
    logic [CW-1:0]    subs_q, subs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   dvs_ext;

    // The partial remainder always fits WIDTH bits signed, so its top bit is redundant before the shift.
    assign r_shift = {r_q[WIDTH-1:0], qs_q[WIDTH-1]};
    assign dvs_ext = {1'b0, dvs_abs_q};

`ifdef DIV_SKIP_LZ_EN
    logic [CW-1:0] lz;
    logic [CW-1:0] n_iter;

    function automatic logic [CW-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    assign lz     = count_lz(qs_q);
    assign n_iter = CW'(WIDTH) - lz;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            qs_q      <= '0;
            dvs_abs_q <= '0;
            dvd_raw_q <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            cnt_q     <= '0;
            adds_q    <= '0;
            subs_q    <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            qs_q      <= qs_d;
            dvs_abs_q <= dvs_abs_d;
            dvd_raw_q <= dvd_raw_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            cnt_q     <= cnt_d;
            adds_q    <= adds_d;
            subs_q    <= subs_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        qs_d      = qs_q;
        dvs_abs_d = dvs_abs_q;
        dvd_raw_d = dvd_raw_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        cnt_d     = cnt_q;
        adds_d    = adds_q;
        subs_d    = subs_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divzero_d = divzero_q;

        // A start strobe wins in every state, aborting whatever was in flight.
        if (bus.inp) begin
            state_d   = S_LOAD;
            qs_d      = bus.dvd[WIDTH-1] ? -bus.dvd : bus.dvd;
            dvs_abs_d = bus.dvs[WIDTH-1] ? -bus.dvs : bus.dvs;
            dvd_raw_d = bus.dvd;
            neg_dvd_d = bus.dvd[WIDTH-1];
            neg_dvs_d = bus.dvs[WIDTH-1];
            r_d       = '0;
            adds_d    = '0;
            subs_d    = '0;
            divzero_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    r_d = '0;
                    if (dvs_abs_q == '0) begin
                        state_d = S_ZERO;
                    end else begin
`ifdef DIV_SKIP_LZ_EN
                        qs_d    = qs_q << lz;
                        cnt_d   = n_iter;
                        state_d = (n_iter == '0) ? S_FIX : S_RUN;
`else
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (!r_q[WIDTH]) begin
                        r_d    = r_shift - dvs_ext;
                        subs_d = subs_q + CW'(1);
                    end else begin
                        r_d    = r_shift + dvs_ext;
                        adds_d = adds_q + CW'(1);
                    end
                    qs_d  = {qs_q[WIDTH-2:0], ~r_d[WIDTH]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    if (r_q[WIDTH]) begin
                        r_d    = r_q + dvs_ext;
                        adds_d = adds_q + CW'(1);
                    end
                    state_d = S_SIGN;
                end
                S_SIGN: begin
                    quot_d  = (neg_dvd_q ^ neg_dvs_q) ? -qs_q : qs_q;
                    rem_d   = neg_dvd_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    state_d = S_IDLE;
                end
                S_ZERO: begin
                    quot_d    = '1;
                    rem_d     = dvd_raw_q;
                    divzero_d = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.done    = (state_q == S_IDLE);
    assign bus.adds    = adds_q;
    assign bus.subs    = subs_q;
    assign bus.quot    = quot_q;
    assign bus.rem     = rem_q;
    assign bus.divzero = divzero_q;
endmodule
